// File: rtl/uart16550_regs_if.sv
// rtl/uart16550_regs_if.sv - byte-wide register bus between bridge and UART core
interface uart16550_regs_if;
    logic [2:0] wb_addr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_we_i;
    logic       wb_re_i;

    modport master (output wb_addr_i, output wb_dat_i, output wb_we_i, output wb_re_i,
                    input wb_dat_o);
    modport slave  (input wb_addr_i, input wb_dat_i, input wb_we_i, input wb_re_i,
                    output wb_dat_o);
endinterface

// File: rtl/uart16550_regs.sv
// rtl/uart16550_regs.sv - 16450-mode UART: registers, baud generator, TX/RX, modem and interrupts
module uart16550_regs (
    input  logic                   clk,
    input  logic                   resetn,
    uart16550_regs_if.slave        bus,
    input  logic [3:0]             modem_inputs,
    output logic                   stx_pad_o,
    input  logic                   srx_pad_i,
    output logic                   rts_pad_o,
    output logic                   dtr_pad_o,
    output logic                   int_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [3:0]  ier_q, ier_d;
    logic [7:0]  lcr_q, lcr_d;
    logic [4:0]  mcr_q, mcr_d;
    logic [7:0]  dll_q, dll_d, dlm_q, dlm_d, scr_q, scr_d, rbr_q, rbr_d, thr_q, thr_d;
    logic        dr_q, dr_d, oe_q, oe_d, pe_q, pe_d, fe_q, fe_d;
    logic        thre_q, thre_d, temt_q, temt_d, thre_int_q, thre_int_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]  tx_state_q, tx_state_d, tx_bit_q, tx_bit_d;
    logic [3:0]  tx_cnt_q, tx_cnt_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_par_q, tx_par_d, tx_stop2_q, tx_stop2_d;
    logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
    logic [2:0]  rx_state_q, rx_state_d, rx_bit_q, rx_bit_d;
    logic [3:0]  rx_cnt_q, rx_cnt_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_perr_q, rx_perr_d;
    logic [3:0]  m_s1_q, m_s1_d, m_s2_q, m_s2_d, m_prev_q, m_prev_d, delta_q, delta_d;

    logic [15:0] divisor;
    logic        tick, dlab, loop_en, tx_line, ser_line;
    logic [2:0]  last_bit;
    logic [7:0]  data_mask, iir, lsr, msr, rd_data;
    logic [3:0]  m_in;
    logic        thr_wr, ier_rise, iir_ack;

    assign divisor   = {dlm_q, dll_q};
    assign tick      = (divisor != 16'd0) && (baud_cnt_q >= divisor - 16'd1);
    assign dlab      = lcr_q[7];
    assign loop_en   = mcr_q[4];
    assign last_bit  = {1'b0, lcr_q[1:0]} + 3'd4;
    assign data_mask = 8'hFF >> (2'd3 - lcr_q[1:0]);

    always_comb begin
        case (tx_state_q)
            S_START: tx_line = 1'b0;
            S_DATA:  tx_line = tx_shift_q[0];
            S_PAR:   tx_line = tx_par_q;
            default: tx_line = 1'b1;
        endcase
    end

    assign ser_line  = tx_line & ~lcr_q[6];
    assign stx_pad_o = loop_en ? 1'b1 : ser_line;
    assign rts_pad_o = mcr_q[1];
    assign dtr_pad_o = mcr_q[0];
    // modem_inputs[0..3] = cts, dsr, ri, dcd; loopback wires RTS->cts, DTR->dsr, OUT1->ri, OUT2->dcd
    assign m_in      = loop_en ? {mcr_q[3], mcr_q[2], mcr_q[0], mcr_q[1]} : modem_inputs;

    assign lsr = {1'b0, temt_q, thre_q, 1'b0, fe_q, pe_q, oe_q, dr_q};
    assign msr = {m_s2_q, delta_q};

    always_comb begin
        if (ier_q[2] && (oe_q || pe_q || fe_q)) iir = 8'h06;
        else if (ier_q[0] && dr_q)              iir = 8'h04;
        else if (ier_q[1] && thre_int_q)        iir = 8'h02;
        else if (ier_q[3] && (|delta_q))        iir = 8'h00;
        else                                    iir = 8'h01;
    end

    assign int_o = ~iir[0];

    always_comb begin
        case (bus.wb_addr_i)
            3'd0:    rd_data = dlab ? dll_q : rbr_q;
            3'd1:    rd_data = dlab ? dlm_q : {4'b0, ier_q};
            3'd2:    rd_data = iir;
            3'd3:    rd_data = lcr_q;
            3'd4:    rd_data = {3'b0, mcr_q};
            3'd5:    rd_data = lsr;
            3'd6:    rd_data = msr;
            default: rd_data = scr_q;
        endcase
    end

    assign bus.wb_dat_o = rd_data;

    always_comb begin
        ier_d = ier_q; lcr_d = lcr_q; mcr_d = mcr_q; dll_d = dll_q; dlm_d = dlm_q;
        scr_d = scr_q; rbr_d = rbr_q; thr_d = thr_q;
        dr_d = dr_q; oe_d = oe_q; pe_d = pe_q; fe_d = fe_q;
        thre_d = thre_q; temt_d = temt_q; thre_int_d = thre_int_q;
        tx_state_d = tx_state_q; tx_bit_d = tx_bit_q; tx_cnt_d = tx_cnt_q;
        tx_shift_d = tx_shift_q; tx_par_d = tx_par_q; tx_stop2_d = tx_stop2_q;
        rx_state_d = rx_state_q; rx_bit_d = rx_bit_q; rx_cnt_d = rx_cnt_q;
        rx_shift_d = rx_shift_q; rx_perr_d = rx_perr_q;
        rx_s1_d = loop_en ? ser_line : srx_pad_i;
        rx_s2_d = rx_s1_q;
        rx_prev_d = rx_s2_q;
        m_s1_d = m_in; m_s2_d = m_s1_q; m_prev_d = m_s2_q;
        delta_d = delta_q;
        thr_wr = 1'b0; ier_rise = 1'b0; iir_ack = 1'b0;
        baud_cnt_d = tick ? 16'd0 : ((divisor == 16'd0) ? 16'd0 : baud_cnt_q + 16'd1);

        // Read side effects come first so that sets below win over same-cycle clears.
        if (bus.wb_re_i) begin
            case (bus.wb_addr_i)
                3'd0:    if (!dlab) dr_d = 1'b0;
                3'd2:    iir_ack = (iir == 8'h02);
                3'd5:    begin oe_d = 1'b0; pe_d = 1'b0; fe_d = 1'b0; end
                3'd6:    delta_d = 4'd0;
                default: ;
            endcase
        end

        if (tick) begin
            case (tx_state_q)
                S_IDLE: if (!thre_q) begin
                    tx_shift_d = thr_q & data_mask;
                    tx_par_d   = (^(thr_q & data_mask)) ^ ~lcr_q[4];
                    thre_d     = 1'b1;
                    tx_cnt_d   = 4'd0;
                    tx_state_d = S_START;
                end
                S_START: begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == 4'd15) begin tx_state_d = S_DATA; tx_bit_d = 3'd0; end
                end
                S_DATA: begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == 4'd15) begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_stop2_d = 1'b0;
                        if (tx_bit_q == last_bit) tx_state_d = lcr_q[3] ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == 4'd15) tx_state_d = S_STOP;
                end
                S_STOP: begin
                    tx_cnt_d = tx_cnt_q + 4'd1;
                    if (tx_cnt_q == 4'd15) begin
                        if (lcr_q[2] && !tx_stop2_q) tx_stop2_d = 1'b1;
                        else begin
                            tx_state_d = S_IDLE;
                            if (thre_q) temt_d = 1'b1;
                        end
                    end
                end
                default: tx_state_d = S_IDLE;
            endcase
        end

        if (rx_state_q == S_IDLE) begin
            if (rx_prev_q && !rx_s2_q) begin
                rx_state_d = S_START; rx_cnt_d = 4'd0; rx_shift_d = 8'd0; rx_perr_d = 1'b0;
            end
        end else if (tick) begin
            rx_cnt_d = rx_cnt_q + 4'd1;
            case (rx_state_q)
                S_START: begin
                    if (rx_cnt_q == 4'd7 && rx_s2_q) rx_state_d = S_IDLE;
                    else if (rx_cnt_q == 4'd15) begin rx_state_d = S_DATA; rx_bit_d = 3'd0; end
                end
                S_DATA: begin
                    if (rx_cnt_q == 4'd7) rx_shift_d[rx_bit_q] = rx_s2_q;
                    if (rx_cnt_q == 4'd15) begin
                        rx_bit_d = rx_bit_q + 3'd1;
                        if (rx_bit_q == last_bit) rx_state_d = lcr_q[3] ? S_PAR : S_STOP;
                    end
                end
                S_PAR: begin
                    if (rx_cnt_q == 4'd7) rx_perr_d = (^rx_shift_q) ^ rx_s2_q ^ ~lcr_q[4];
                    if (rx_cnt_q == 4'd15) rx_state_d = S_STOP;
                end
                S_STOP: if (rx_cnt_q == 4'd7) begin
                    rbr_d = rx_shift_q;
                    dr_d  = 1'b1;
                    if (dr_q) oe_d = 1'b1;
                    if (lcr_q[3] && rx_perr_q) pe_d = 1'b1;
                    if (!rx_s2_q) fe_d = 1'b1;
                    rx_state_d = S_IDLE;
                end
                default: rx_state_d = S_IDLE;
            endcase
        end

        delta_d = delta_d | {m_s2_q[3] ^ m_prev_q[3], m_prev_q[2] & ~m_s2_q[2],
                             m_s2_q[1] ^ m_prev_q[1], m_s2_q[0] ^ m_prev_q[0]};

        if (bus.wb_we_i) begin
            case (bus.wb_addr_i)
                3'd0: if (dlab) begin dll_d = bus.wb_dat_i; baud_cnt_d = 16'd0; end
                      else begin
                          thr_d = bus.wb_dat_i; thre_d = 1'b0; temt_d = 1'b0; thr_wr = 1'b1;
                      end
                3'd1: if (dlab) begin dlm_d = bus.wb_dat_i; baud_cnt_d = 16'd0; end
                      else begin
                          ier_d    = bus.wb_dat_i[3:0];
                          ier_rise = bus.wb_dat_i[1] && !ier_q[1] && thre_q;
                      end
                3'd3:    lcr_d = bus.wb_dat_i;
                3'd4:    mcr_d = bus.wb_dat_i[4:0];
                3'd7:    scr_d = bus.wb_dat_i;
                default: ;
            endcase
        end

        if (iir_ack || thr_wr) thre_int_d = 1'b0;
        if ((thre_d && !thre_q) || ier_rise) thre_int_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ier_q <= 4'd0; lcr_q <= 8'h03; mcr_q <= 5'd0; dll_q <= 8'd0; dlm_q <= 8'd0;
            scr_q <= 8'd0; rbr_q <= 8'd0; thr_q <= 8'd0;
            dr_q <= 1'b0; oe_q <= 1'b0; pe_q <= 1'b0; fe_q <= 1'b0;
            thre_q <= 1'b1; temt_q <= 1'b1; thre_int_q <= 1'b0;
            baud_cnt_q <= 16'd0;
            tx_state_q <= S_IDLE; tx_bit_q <= 3'd0; tx_cnt_q <= 4'd0;
            tx_shift_q <= 8'd0; tx_par_q <= 1'b0; tx_stop2_q <= 1'b0;
            rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_prev_q <= 1'b1;
            rx_state_q <= S_IDLE; rx_bit_q <= 3'd0; rx_cnt_q <= 4'd0;
            rx_shift_q <= 8'd0; rx_perr_q <= 1'b0;
            m_s1_q <= 4'd0; m_s2_q <= 4'd0; m_prev_q <= 4'd0; delta_q <= 4'd0;
        end else begin
            ier_q <= ier_d; lcr_q <= lcr_d; mcr_q <= mcr_d; dll_q <= dll_d; dlm_q <= dlm_d;
            scr_q <= scr_d; rbr_q <= rbr_d; thr_q <= thr_d;
            dr_q <= dr_d; oe_q <= oe_d; pe_q <= pe_d; fe_q <= fe_d;
            thre_q <= thre_d; temt_q <= temt_d; thre_int_q <= thre_int_d;
            baud_cnt_q <= baud_cnt_d;
            tx_state_q <= tx_state_d; tx_bit_q <= tx_bit_d; tx_cnt_q <= tx_cnt_d;
            tx_shift_q <= tx_shift_d; tx_par_q <= tx_par_d; tx_stop2_q <= tx_stop2_d;
            rx_s1_q <= rx_s1_d; rx_s2_q <= rx_s2_d; rx_prev_q <= rx_prev_d;
            rx_state_q <= rx_state_d; rx_bit_q <= rx_bit_d; rx_cnt_q <= rx_cnt_d;
            rx_shift_q <= rx_shift_d; rx_perr_q <= rx_perr_d;
            m_s1_q <= m_s1_d; m_s2_q <= m_s2_d; m_prev_q <= m_prev_d; delta_q <= delta_d;
        end
    end
endmodule

// File: tb/tb_uart16550_regs.sv
// tb/tb_uart16550_regs.sv - directed self-checking bench for uart16550_regs
module tb_uart16550_regs;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [3:0] modem_inputs = 4'd0;
    logic       srx_pad_i = 1'b1;
    logic       stx_pad_o, rts_pad_o, dtr_pad_o, int_o;
    int         cmp_count = 0;
    int         err_count = 0;

    uart16550_regs_if bus ();

    uart16550_regs dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus          (bus),
        .modem_inputs (modem_inputs),
        .stx_pad_o    (stx_pad_o),
        .srx_pad_i    (srx_pad_i),
        .rts_pad_o    (rts_pad_o),
        .dtr_pad_o    (dtr_pad_o),
        .int_o        (int_o)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        bus.wb_addr_i = a; bus.wb_dat_i = d; bus.wb_we_i = 1'b1;
        step(1);
        bus.wb_we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        bus.wb_addr_i = a; bus.wb_re_i = 1'b1;
        #1 d = bus.wb_dat_o;
        step(1);
        bus.wb_re_i = 1'b0;
    endtask

    task automatic wait_temt;
        int n = 0;
        bus.wb_addr_i = 3'd5;
        #1;
        while (bus.wb_dat_o[6] !== 1'b1 && n < 2000) begin step(1); n++; end
        cmp_count++;
        if (bus.wb_dat_o[6] !== 1'b1) begin
            err_count++; $display("FAIL temt_wait: lsr %h, required TEMT=1", bus.wb_dat_o);
        end
    endtask

    task automatic wait_int;
        int n = 0;
        while (int_o !== 1'b1 && n < 2000) begin step(1); n++; end
        cmp_count++;
        if (int_o !== 1'b1) begin err_count++; $display("FAIL int_wait: int_o %b, required 1", int_o); end
    endtask

    task automatic wait_dr;
        int n = 0;
        bus.wb_addr_i = 3'd5;
        #1;
        while (bus.wb_dat_o[0] !== 1'b1 && n < 2000) begin step(1); n++; end
        cmp_count++;
        if (bus.wb_dat_o[0] !== 1'b1) begin
            err_count++; $display("FAIL dr_wait: lsr %h, required DR=1", bus.wb_dat_o);
        end
    endtask

    task automatic send_serial(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            srx_pad_i = bits[i];
            step(32);
        end
        srx_pad_i = 1'b1;
        step(8);
    endtask

    task automatic test_reset;
        logic [7:0] d;
        bus_read(3'd3, d);
        cmp_count++; if (d !== 8'h03) begin err_count++; $display("FAIL reset_lcr: %h required 03", d); end
        bus_read(3'd5, d);
        cmp_count++; if (d !== 8'h60) begin err_count++; $display("FAIL reset_lsr: %h required 60", d); end
        bus_read(3'd2, d);
        cmp_count++; if (d !== 8'h01) begin err_count++; $display("FAIL reset_iir: %h required 01", d); end
        bus_read(3'd1, d);
        cmp_count++; if (d !== 8'h00) begin err_count++; $display("FAIL reset_ier: %h required 00", d); end
        cmp_count++;
        if ({stx_pad_o, int_o, rts_pad_o, dtr_pad_o} !== 4'b1000) begin
            err_count++;
            $display("FAIL reset_pins: stx/int/rts/dtr %b required 1000", {stx_pad_o, int_o, rts_pad_o, dtr_pad_o});
        end
    endtask

    task automatic test_tx;
        logic       s[0:319];
        logic [7:0] d, lsr_mid;
        logic [7:0] byte_v = 8'h55;
        logic       exp_b;
        int         n = 0;
        bus_write(3'd3, 8'h83);
        bus_write(3'd0, 8'h02);
        bus_write(3'd1, 8'h00);
        bus_write(3'd3, 8'h03);
        bus_write(3'd0, 8'h55);
        bus.wb_addr_i = 3'd5;
        while (stx_pad_o !== 1'b0 && n < 100) begin step(1); n++; end
        cmp_count++;
        if (stx_pad_o !== 1'b0) begin err_count++; $display("FAIL tx_start_wait: stx %b required 0", stx_pad_o); end
        lsr_mid = 8'h00;
        for (int i = 0; i < 320; i++) begin
            s[i] = stx_pad_o;
            if (i == 100) lsr_mid = bus.wb_dat_o;
            step(1);
        end
        for (int i = 0; i < 10; i++) begin
            exp_b = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : byte_v[i-1];
            cmp_count++;
            if (s[32*i+16] !== exp_b) begin
                err_count++; $display("FAIL tx_bit%0d: stx %b required %b", i, s[32*i+16], exp_b);
            end
        end
        cmp_count++;
        if ({s[31], s[32]} !== 2'b01) begin
            err_count++; $display("FAIL tx_bit_width: samples 31/32 %b required 01", {s[31], s[32]});
        end
        cmp_count++;
        if (lsr_mid !== 8'h20) begin err_count++; $display("FAIL tx_lsr_busy: %h required 20", lsr_mid); end
        wait_temt();
        bus_read(3'd5, d);
        cmp_count++; if (d !== 8'h60) begin err_count++; $display("FAIL tx_lsr_done: %h required 60", d); end
    endtask

    task automatic test_loopback_rx;
        logic [7:0] d;
        logic       saw_low = 1'b0;
        int         n = 0;
        bus_write(3'd4, 8'h10);
        bus_write(3'd1, 8'h01);
        bus_write(3'd0, 8'hA3);
        while (int_o !== 1'b1 && n < 2000) begin
            if (stx_pad_o !== 1'b1) saw_low = 1'b1;
            step(1); n++;
        end
        cmp_count++;
        if (int_o !== 1'b1) begin err_count++; $display("FAIL lb_int: int_o %b required 1", int_o); end
        cmp_count++;
        if (saw_low !== 1'b0) begin err_count++; $display("FAIL lb_stx_idle: saw low %b required 0", saw_low); end
        bus_read(3'd2, d);
        cmp_count++; if (d !== 8'h04) begin err_count++; $display("FAIL lb_iir: %h required 04", d); end
        bus_read(3'd0, d);
        cmp_count++; if (d !== 8'hA3) begin err_count++; $display("FAIL lb_rbr: %h required a3", d); end
        bus_read(3'd5, d);
        cmp_count++; if (d[0] !== 1'b0) begin err_count++; $display("FAIL lb_dr_clear: lsr %h required DR=0", d); end
        cmp_count++; if (int_o !== 1'b0) begin err_count++; $display("FAIL lb_int_clear: int_o %b required 0", int_o); end
        wait_temt();
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        bus_write(3'd1, 8'h04);
        bus_write(3'd0, 8'h11);
        step(8);
        bus_write(3'd0, 8'h22);
        wait_int();
        bus_read(3'd2, d);
        cmp_count++; if (d !== 8'h06) begin err_count++; $display("FAIL ovr_iir: %h required 06", d); end
        bus_read(3'd5, d);
        cmp_count++; if ((d & 8'h1F) !== 8'h03) begin err_count++; $display("FAIL ovr_lsr: %h required xx03", d); end
        cmp_count++; if (int_o !== 1'b0) begin err_count++; $display("FAIL ovr_int_clear: int_o %b required 0", int_o); end
        bus_read(3'd0, d);
        cmp_count++; if (d !== 8'h22) begin err_count++; $display("FAIL ovr_rbr: %h required 22", d); end
        bus_read(3'd5, d);
        cmp_count++; if ((d & 8'h0F) !== 8'h00) begin err_count++; $display("FAIL ovr_oe_clear: %h required xx00", d); end
        wait_temt();
    endtask

    task automatic test_parity_framing;
        logic [7:0] d;
        bus_write(3'd1, 8'h00);
        bus_write(3'd3, 8'h1B);
        bus_write(3'd0, 8'h07);
        wait_dr();
        bus_read(3'd5, d);
        cmp_count++; if ((d & 8'h0F) !== 8'h01) begin err_count++; $display("FAIL par_even_ok: lsr %h required xx01", d); end
        bus_read(3'd0, d);
        cmp_count++; if (d !== 8'h07) begin err_count++; $display("FAIL par_even_rbr: %h required 07", d); end
        wait_temt();
        bus_write(3'd4, 8'h00);
        bus_write(3'd3, 8'h0B);
        send_serial(16'b0000_0_1_1_00000111_0, 11);
        bus_read(3'd5, d);
        cmp_count++; if ((d & 8'h0F) !== 8'h05) begin err_count++; $display("FAIL par_odd_err: lsr %h required xx05", d); end
        bus_read(3'd0, d);
        cmp_count++; if (d !== 8'h07) begin err_count++; $display("FAIL par_odd_rbr: %h required 07", d); end
        bus_write(3'd3, 8'h03);
        send_serial(16'b000000_0_01011010_0, 10);
        bus_read(3'd5, d);
        cmp_count++; if ((d & 8'h0F) !== 8'h09) begin err_count++; $display("FAIL frame_err: lsr %h required xx09", d); end
        bus_read(3'd0, d);
        cmp_count++; if (d !== 8'h5A) begin err_count++; $display("FAIL frame_rbr: %h required 5a", d); end
    endtask

    task automatic test_msr;
        logic [7:0] d;
        bus_read(3'd6, d);
        cmp_count++; if (d !== 8'h00) begin err_count++; $display("FAIL msr_idle: %h required 00", d); end
        bus_write(3'd1, 8'h08);
        modem_inputs = 4'b0001;
        step(5);
        bus_read(3'd2, d);
        cmp_count++; if (d !== 8'h00) begin err_count++; $display("FAIL msr_iir: %h required 00", d); end
        cmp_count++; if (int_o !== 1'b1) begin err_count++; $display("FAIL msr_int: int_o %b required 1", int_o); end
        bus_read(3'd6, d);
        cmp_count++; if (d !== 8'h11) begin err_count++; $display("FAIL msr_delta: %h required 11", d); end
        cmp_count++; if (int_o !== 1'b0) begin err_count++; $display("FAIL msr_int_clear: int_o %b required 0", int_o); end
        bus_read(3'd6, d);
        cmp_count++; if (d !== 8'h10) begin err_count++; $display("FAIL msr_cleared: %h required 10", d); end
    endtask

    task automatic test_regs_and_thre_int;
        logic [7:0] d;
        bus_write(3'd1, 8'h02);
        cmp_count++; if (int_o !== 1'b1) begin err_count++; $display("FAIL thre_int_set: int_o %b required 1", int_o); end
        bus_read(3'd2, d);
        cmp_count++; if (d !== 8'h02) begin err_count++; $display("FAIL thre_iir: %h required 02", d); end
        bus_read(3'd2, d);
        cmp_count++; if (d !== 8'h01) begin err_count++; $display("FAIL thre_iir_ack: %h required 01", d); end
        bus_write(3'd7, 8'hA5);
        bus_read(3'd7, d);
        cmp_count++; if (d !== 8'hA5) begin err_count++; $display("FAIL scr: %h required a5", d); end
        bus_write(3'd3, 8'h83);
        bus_read(3'd0, d);
        cmp_count++; if (d !== 8'h02) begin err_count++; $display("FAIL dll_read: %h required 02", d); end
        bus_write(3'd3, 8'h03);
        bus_write(3'd4, 8'h03);
        cmp_count++;
        if ({rts_pad_o, dtr_pad_o} !== 2'b11) begin
            err_count++; $display("FAIL mcr_pins: rts/dtr %b required 11", {rts_pad_o, dtr_pad_o});
        end
    endtask

    initial begin
        bus.wb_addr_i = 3'd0; bus.wb_dat_i = 8'd0; bus.wb_we_i = 1'b0; bus.wb_re_i = 1'b0;
        step(3);
        resetn = 1'b1;
        step(2);
        test_reset();
        test_tx();
        test_loopback_rx();
        test_overrun();
        test_parity_framing();
        test_msr();
        test_regs_and_thre_int();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end
endmodule
